// File: rtl/shift_pkg.sv
// shift_pkg: shared types and helpers for the serial shift path (RX engine and TX path).
package shift_pkg;
    typedef enum logic {SHIFT_MSB_FIRST, SHIFT_LSB_FIRST} shift_dir_t;
    localparam int MAX_WIDTH = 64;
    localparam int IDX_W = $clog2(MAX_WIDTH);
    function automatic logic out_bit(input logic [MAX_WIDTH-1:0] value, input logic [IDX_W-1:0] msb_idx, input shift_dir_t dir);
        return (dir == SHIFT_LSB_FIRST) ? value[0] : value[msb_idx];
    endfunction
endpackage

// File: rtl/shift_bit_counter.sv
// shift_bit_counter: per-frame bit counter; wrap flags the shift that completes a frame.
module shift_bit_counter #(
    parameter int WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         clear,
    input  logic                         inc,
    output logic [$clog2(WIDTH+1)-1:0]   count,
    output logic                         wrap
);
    localparam int CNT_W = $clog2(WIDTH+1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH-1);
    assign wrap = inc && !clear && count == LAST;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) count <= '0;
        else if (clear) count <= '0;
        else if (inc) count <= wrap ? '0 : count + CNT_W'(1);
    end
endmodule

// File: rtl/shift_frame_engine.sv
// shift_frame_engine: width-configurable MSB/LSB-first shift register with bit counting
// and a receive holding register captured on each completed frame.
module shift_frame_engine
    import shift_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       peripheralClkEdge,
    input  logic                       peripheralClkFall,
    input  logic                       parallelLoad,
    input  logic [WIDTH-1:0]           parallelDataIn,
    input  logic                       lsbFirst,
    input  logic                       serialDataIn,
    output logic [WIDTH-1:0]           parallelDataOut,
    output logic                       serialDataOut,
    output logic [WIDTH-1:0]           rxData,
    output logic                       frameDone,
    output logic [$clog2(WIDTH+1)-1:0] bitCount
);
    logic [WIDTH-1:0] shreg, shifted, shreg_next;
    shift_dir_t mode, mode_next;
    logic shift_en, wrap;
    assign shift_en = peripheralClkEdge && !parallelLoad;
    assign parallelDataOut = shreg;
    always_comb begin
        shifted    = (mode == SHIFT_MSB_FIRST) ? {shreg[WIDTH-2:0], serialDataIn} : {serialDataIn, shreg[WIDTH-1:1]};
        shreg_next = parallelLoad ? parallelDataIn : shift_en ? shifted : shreg;
        mode_next  = parallelLoad ? shift_dir_t'(lsbFirst) : mode;
    end
    shift_bit_counter #(.WIDTH(WIDTH)) u_cnt (
        .clk   (clk),
        .reset (reset),
        .clear (parallelLoad),
        .inc   (shift_en),
        .count (bitCount),
        .wrap  (wrap)
    );
    // A load drives the first output bit of the new frame, so it shares the fall-strobe path.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shreg         <= '0;
            mode          <= SHIFT_MSB_FIRST;
            serialDataOut <= 1'b0;
            rxData        <= '0;
            frameDone     <= 1'b0;
        end else begin
            shreg     <= shreg_next;
            mode      <= mode_next;
            frameDone <= wrap;
            if (wrap) rxData <= shifted;
            if (parallelLoad || peripheralClkFall)
                serialDataOut <= out_bit(MAX_WIDTH'(shreg_next), IDX_W'(WIDTH-1), mode_next);
        end
    end
endmodule

// File: tb/tb_shift_frame_engine.sv
// tb_shift_frame_engine: drives 8- and 16-bit engines in lockstep against a frame-level reference model.
module tb_shift_frame_engine;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic peripheralClkEdge = 1'b0, peripheralClkFall = 1'b0, parallelLoad = 1'b0;
    logic lsbFirst = 1'b0, serialDataIn = 1'b0;
    logic [15:0] pdi = '0;
    logic [7:0]  pdo8, rx8;
    logic [15:0] pdo16, rx16;
    logic        sdo8, done8, sdo16, done16;
    logic [3:0]  cnt8;
    logic [4:0]  cnt16;
    int n_tests = 0, n_fail = 0;
    logic [15:0] m_sh [2], m_rx [2];
    int          m_cnt [2];
    bit          m_lsb [2], m_done [2], m_sdo [2];
    int          wd [2] = '{8, 16};

    always #5 clk = ~clk;

    shift_frame_engine #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .peripheralClkEdge(peripheralClkEdge), .peripheralClkFall(peripheralClkFall),
        .parallelLoad(parallelLoad), .parallelDataIn(pdi[7:0]), .lsbFirst(lsbFirst), .serialDataIn(serialDataIn),
        .parallelDataOut(pdo8), .serialDataOut(sdo8), .rxData(rx8), .frameDone(done8), .bitCount(cnt8));
    shift_frame_engine #(.WIDTH(16)) dut16 (
        .clk(clk), .reset(reset), .peripheralClkEdge(peripheralClkEdge), .peripheralClkFall(peripheralClkFall),
        .parallelLoad(parallelLoad), .parallelDataIn(pdi), .lsbFirst(lsbFirst), .serialDataIn(serialDataIn),
        .parallelDataOut(pdo16), .serialDataOut(sdo16), .rxData(rx16), .frameDone(done16), .bitCount(cnt16));

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_sh[k] = '0; m_rx[k] = '0; m_cnt[k] = 0; m_lsb[k] = 0; m_done[k] = 0; m_sdo[k] = 0;
        end
    endtask

    // One clock: apply inputs, advance the frame model, then settle 1 time unit past the edge.
    task automatic step(input bit ld, input bit ed, input bit fl, input logic [15:0] pd, input bit lsb, input bit si);
        parallelLoad = ld; peripheralClkEdge = ed; peripheralClkFall = fl;
        pdi = pd; lsbFirst = lsb; serialDataIn = si;
        @(posedge clk);
        if (reset) model_reset();
        else for (int k = 0; k < 2; k++) begin
            int w = wd[k];
            logic [15:0] mask = (w == 16) ? 16'hFFFF : 16'h00FF;
            logic [15:0] nxt = m_sh[k];
            m_done[k] = 0;
            if (ld) begin
                nxt = pd & mask; m_lsb[k] = lsb; m_cnt[k] = 0;
            end else if (ed) begin
                nxt = m_lsb[k] ? ((m_sh[k] >> 1) | (16'(si) << (w - 1))) : (((m_sh[k] << 1) | 16'(si)) & mask);
                m_cnt[k]++;
                if (m_cnt[k] == w) begin
                    m_cnt[k] = 0; m_rx[k] = nxt; m_done[k] = 1;
                end
            end
            if (ld || fl) m_sdo[k] = m_lsb[k] ? nxt[0] : nxt[w-1];
            m_sh[k] = nxt;
        end
        #1;
        parallelLoad = 0; peripheralClkEdge = 0; peripheralClkFall = 0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #2;
        n_tests++;
        if ({pdo8, sdo8, rx8, done8, cnt8} !== 22'h0) begin
            n_fail++; $display("FAIL reset8 got %h exp 0", {pdo8, sdo8, rx8, done8, cnt8});
        end
        n_tests++;
        if ({pdo16, sdo16, rx16, done16, cnt16} !== 39'h0) begin
            n_fail++; $display("FAIL reset16 got %h exp 0", {pdo16, sdo16, rx16, done16, cnt16});
        end
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_msb_basic();
        step(1, 0, 0, 16'h0080, 0, 0);
        n_tests++;
        if ({pdo8, sdo8} !== {8'h80, 1'b1}) begin
            n_fail++; $display("FAIL msb_load got pdo=%h sdo=%b exp pdo=80 sdo=1", pdo8, sdo8);
        end
        step(0, 1, 0, 0, 0, 1);
        n_tests++;
        if ({pdo8, cnt8} !== {8'h01, 4'd1}) begin
            n_fail++; $display("FAIL msb_shift got pdo=%h cnt=%0d exp pdo=01 cnt=1", pdo8, cnt8);
        end
        step(0, 0, 1, 0, 0, 0);
        n_tests++;
        if (sdo8 !== 1'b0) begin
            n_fail++; $display("FAIL msb_fall got sdo=%b exp 0", sdo8);
        end
    endtask

    task automatic test_full_frame_msb();
        logic [7:0] stream = '0;
        logic [7:0] din = 8'h3C;
        step(1, 0, 0, 16'h00A5, 0, 0);
        for (int i = 0; i < 8; i++) begin
            step(0, 0, 1, 0, 0, 0);
            stream[7-i] = sdo8;
            step(0, 1, 0, 0, 0, din[7-i]);
            n_tests++;
            if (done8 !== (i == 7)) begin
                n_fail++; $display("FAIL frame_done edge %0d got %b exp %b", i, done8, i == 7);
            end
        end
        n_tests++;
        if (rx8 !== 8'h3C || pdo8 !== 8'h3C) begin
            n_fail++; $display("FAIL frame_rx got rx=%h pdo=%h exp 3c", rx8, pdo8);
        end
        n_tests++;
        if (stream !== 8'hA5) begin
            n_fail++; $display("FAIL frame_stream got %h exp a5", stream);
        end
        step(0, 0, 0, 0, 0, 0);
        n_tests++;
        if (done8 !== 1'b0) begin
            n_fail++; $display("FAIL frame_pulse got done=%b exp 0", done8);
        end
    endtask

    task automatic test_lsb();
        logic [7:0] din = 8'hC3;
        step(1, 0, 0, 16'h0001, 1, 0);
        n_tests++;
        if (sdo8 !== 1'b1) begin
            n_fail++; $display("FAIL lsb_first_bit got %b exp 1", sdo8);
        end
        for (int i = 0; i < 8; i++) step(0, 1, i == 3, 0, i >= 4 ? 1'b0 : 1'b1, din[i]);
        n_tests++;
        if ({rx8, done8, cnt8} !== {8'hC3, 1'b1, 4'd0}) begin
            n_fail++; $display("FAIL lsb_rx got rx=%h done=%b cnt=%0d exp c3/1/0", rx8, done8, cnt8);
        end
    endtask

    task automatic test_back_to_back();
        int pulses = 0;
        step(0, 1, 0, 0, 0, 0);
        step(1, 1, 0, 16'h005A, 0, 1);
        n_tests++;
        if ({pdo8, cnt8, done8} !== {8'h5A, 4'd0, 1'b0}) begin
            n_fail++; $display("FAIL collision got pdo=%h cnt=%0d done=%b exp 5a/0/0", pdo8, cnt8, done8);
        end
        for (int i = 0; i < 17; i++) begin
            step(0, i < 16, 0, 0, 0, 1'($urandom));
            if (done8) pulses++;
        end
        n_tests++;
        if (pulses !== 2) begin
            n_fail++; $display("FAIL back_to_back got %0d pulses exp 2", pulses);
        end
    endtask

    task automatic test_width16();
        logic [15:0] din = 16'hBEEF;
        step(1, 0, 0, 16'h0000, 0, 0);
        for (int i = 0; i < 15; i++) step(0, 1, 0, 0, 0, din[15-i]);
        n_tests++;
        if (cnt16 !== 5'd15) begin
            n_fail++; $display("FAIL w16_cnt15 got %0d exp 15", cnt16);
        end
        step(0, 1, 0, 0, 0, din[0]);
        n_tests++;
        if ({rx16, cnt16, done16} !== {16'hBEEF, 5'd0, 1'b1}) begin
            n_fail++; $display("FAIL w16_frame got rx=%h cnt=%0d done=%b exp beef/0/1", rx16, cnt16, done16);
        end
    endtask

    task automatic test_random();
        for (int s = 0; s < 400; s++) begin
            step($urandom_range(0, 9) == 0, 1'($urandom), 1'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
            n_tests++;
            if ({pdo8, sdo8, rx8, done8, cnt8} !== {m_sh[0][7:0], m_sdo[0], m_rx[0][7:0], m_done[0], 4'(m_cnt[0])}) begin
                n_fail++;
                $display("FAIL rand8 step %0d got %h exp %h", s, {pdo8, sdo8, rx8, done8, cnt8},
                         {m_sh[0][7:0], m_sdo[0], m_rx[0][7:0], m_done[0], 4'(m_cnt[0])});
            end
            n_tests++;
            if ({pdo16, sdo16, rx16, done16, cnt16} !== {m_sh[1], m_sdo[1], m_rx[1], m_done[1], 5'(m_cnt[1])}) begin
                n_fail++;
                $display("FAIL rand16 step %0d got %h exp %h", s, {pdo16, sdo16, rx16, done16, cnt16},
                         {m_sh[1], m_sdo[1], m_rx[1], m_done[1], 5'(m_cnt[1])});
            end
        end
    endtask

    task automatic test_async_reset();
        step(1, 0, 1, 16'hFFFF, 0, 1);
        for (int i = 0; i < 3; i++) step(0, 1, 1, 0, 0, 1);
        #2 reset = 1'b1;
        #1;
        n_tests++;
        if ({pdo8, sdo8, rx8, done8, cnt8, pdo16, sdo16, rx16, done16, cnt16} !== 61'h0) begin
            n_fail++; $display("FAIL async_reset got %h/%h exp 0", {pdo8, sdo8, rx8, done8, cnt8}, {pdo16, sdo16, rx16, done16, cnt16});
        end
        model_reset();
        step(1, 1, 1, 16'hFFFF, 1, 1);
        n_tests++;
        if ({pdo8, sdo8, rx8, done8, cnt8} !== 22'h0) begin
            n_fail++; $display("FAIL reset_strobe got %h exp 0", {pdo8, sdo8, rx8, done8, cnt8});
        end
        reset = 1'b0;
        step(0, 1, 0, 0, 0, 1);
        n_tests++;
        if ({pdo8, cnt8, rx8} !== {8'h01, 4'd1, 8'h00}) begin
            n_fail++; $display("FAIL post_reset got pdo=%h cnt=%0d rx=%h exp 01/1/00", pdo8, cnt8, rx8);
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_msb_basic();
        test_full_frame_msb();
        test_lsb();
        test_back_to_back();
        test_width16();
        test_random();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
